// File: rtl/fifo_pkg.sv
// Shared helpers for the async FIFO: pointer type and binary/Gray conversions.
// The conversions work on a zero-extended wide word, so any pointer width up to 32 bits can use them.
package fifo_pkg;

  localparam int FIFO_ADDR_SIZE = 4;
  localparam int WIDE_W         = 32;

  typedef logic [FIFO_ADDR_SIZE:0] ptr_t;
  typedef logic [WIDE_W-1:0]       wide_t;

  function automatic wide_t bin2gray(input wide_t b);
    return b ^ (b >> 1);
  endfunction

  // Leading zero bits leave the low bits unchanged, so callers keep only their own width.
  function automatic wide_t gray2bin(input wide_t g);
    wide_t b;
    b[WIDE_W-1] = g[WIDE_W-1];
    for (int i = WIDE_W - 2; i >= 0; i--) begin
      b[i] = b[i+1] ^ g[i];
    end
    return b;
  endfunction

endpackage

// File: rtl/fifo_wr_arb_ctrl_if.sv
// Requester handshake, synchronized read pointer and memory write port of the FIFO write side.
interface fifo_wr_arb_ctrl_if #(
    parameter int ADDR_SIZE  = 4,
    parameter int DATA_WIDTH = 8,
    parameter int NUM_REQ    = 2
);
    logic [NUM_REQ-1:0]            i_valid;
    logic [NUM_REQ*DATA_WIDTH-1:0] i_data;
    logic [NUM_REQ-1:0]            o_ready;
    logic [ADDR_SIZE:0]            i_rptr_sync;
    logic [ADDR_SIZE:0]            o_wptr;
    logic                          o_wen;
    logic [ADDR_SIZE-1:0]          o_waddr;
    logic [DATA_WIDTH-1:0]         o_wdata;
    logic                          o_full;
    logic                          o_afull;
    logic [ADDR_SIZE:0]            o_level;
    logic                          o_err;

    modport master (
        output i_valid, i_data, i_rptr_sync,
        input  o_ready, o_wptr, o_wen, o_waddr, o_wdata, o_full, o_afull, o_level, o_err
    );

    modport slave (
        input  i_valid, i_data, i_rptr_sync,
        output o_ready, o_wptr, o_wen, o_waddr, o_wdata, o_full, o_afull, o_level, o_err
    );
endinterface

// File: rtl/fifo_wr_arb_ctrl_rr_arbiter.sv
// Round-robin arbiter: searches upward from the last granted requester, moving only on advance.
module rr_arbiter #(
    parameter int NUM_REQ = 2
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [NUM_REQ-1:0] req,
    input  logic               advance,
    output logic [NUM_REQ-1:0] grant
);
    localparam int IW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

    logic [IW-1:0] last;
    logic [IW-1:0] grant_idx;
    logic          found;
    int            idx;

    // NOTE: combinational blocks use blocking '=' and assign every output a default first,
    // so no latch is inferred when no requester is valid.
    always_comb begin
        grant     = '0;
        grant_idx = last;
        found     = 1'b0;
        idx       = 0;
        for (int off = 1; off <= NUM_REQ; off++) begin
            idx = (int'(last) + off) % NUM_REQ;
            if (!found && req[idx]) begin
                found      = 1'b1;
                grant[idx] = 1'b1;
                grant_idx  = IW'(idx);
            end
        end
    end

    // NOTE: state registers use non-blocking '<=' so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            last <= IW'(NUM_REQ - 1);
        end else if (advance) begin
            last <= grant_idx;
        end
    end
endmodule

// File: rtl/fifo_wr_arb_ctrl.sv
// Write-side controller of the async FIFO: round-robin requester arbitration, write pointer
// in binary and Gray form, and full/almost-full/level flags against the synchronized read pointer.
module fifo_wr_arb_ctrl
    import fifo_pkg::*;
#(
    parameter int ADDR_SIZE    = 4,
    parameter int DATA_WIDTH   = 8,
    parameter int NUM_REQ      = 2,
    parameter int AFULL_THRESH = 12
) (
    input logic               clk,
    input logic               rst,
    fifo_wr_arb_ctrl_if.slave bus
);
    localparam int PW = ADDR_SIZE + 1;

    logic [NUM_REQ-1:0]    grant;
    logic [NUM_REQ-1:0]    ready;
    logic                  wen;
    logic [DATA_WIDTH-1:0] wdata;
    logic [PW-1:0]         wbin, wbin_next, wgray_next, rbin, level_next, rptr_q, full_cmp;
    wide_t                 wgray_w, rbin_w;
    logic                  unused_hi;

    rr_arbiter #(.NUM_REQ(NUM_REQ)) u_arb (
        .clk     (clk),
        .rst     (rst),
        .req     (bus.i_valid),
        .advance (wen),
        .grant   (grant)
    );

    // Ready is forced low during reset so an in-flight request is dropped without a write.
    always_comb begin
        ready = rst ? (grant & {NUM_REQ{~bus.o_full}}) : '0;
        wen   = |(bus.i_valid & ready);
        wdata = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            if (grant[k]) wdata = wdata | bus.i_data[k*DATA_WIDTH +: DATA_WIDTH];
        end
    end

    assign wbin_next  = wbin + PW'(wen);
    assign wgray_w    = bin2gray(wide_t'(wbin_next));
    assign wgray_next = wgray_w[PW-1:0];
    assign rbin_w     = gray2bin(wide_t'(bus.i_rptr_sync));
    assign rbin       = rbin_w[PW-1:0];
    assign level_next = wbin_next - rbin;
    assign unused_hi  = ^{wgray_w[WIDE_W-1:PW], rbin_w[WIDE_W-1:PW]};

    // Full when the next write pointer is one lap ahead of the read pointer (top two Gray bits inverted).
    assign full_cmp = {~bus.i_rptr_sync[PW-1:PW-2], bus.i_rptr_sync[PW-3:0]};

    assign bus.o_ready = ready;
    assign bus.o_wen   = wen;
    assign bus.o_waddr = wbin[ADDR_SIZE-1:0];
    assign bus.o_wdata = wdata;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wbin        <= '0;
            bus.o_wptr  <= '0;
            bus.o_full  <= 1'b0;
            bus.o_afull <= 1'b0;
            bus.o_level <= '0;
            bus.o_err   <= 1'b0;
            rptr_q      <= '0;
        end else begin
            wbin        <= wbin_next;
            bus.o_wptr  <= wgray_next;
            bus.o_full  <= (wgray_next == full_cmp);
            bus.o_afull <= (level_next >= PW'(AFULL_THRESH));
            bus.o_level <= level_next;
            rptr_q      <= bus.i_rptr_sync;
            // A synchronized Gray pointer may move by one bit only; more means a broken CDC path.
            if ($countones(bus.i_rptr_sync ^ rptr_q) > 1) bus.o_err <= 1'b1;
        end
    end
endmodule

// File: tb/tb_fifo_wr_arb_ctrl.sv
// Directed bench for fifo_wr_arb_ctrl; the read side is emulated by driving i_rptr_sync with Gray values.
module tb_fifo_wr_arb_ctrl;
    localparam int AS = 4;
    localparam int DW = 8;
    localparam int NR = 2;
    localparam int AT = 12;

    logic clk = 1'b0;
    logic rst;
    int   n_checks = 0;
    int   n_fail   = 0;

    always #5 clk = ~clk;

    fifo_wr_arb_ctrl_if #(.ADDR_SIZE(AS), .DATA_WIDTH(DW), .NUM_REQ(NR)) bus ();

    fifo_wr_arb_ctrl #(.ADDR_SIZE(AS), .DATA_WIDTH(DW), .NUM_REQ(NR), .AFULL_THRESH(AT)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    function automatic logic [4:0] gray5(input logic [4:0] b);
        return b ^ (b >> 1);
    endfunction

    task automatic apply_reset();
        rst = 1'b0;
        bus.i_valid = '0;
        bus.i_data = '0;
        bus.i_rptr_sync = '0;
        repeat (2) @(negedge clk);
        rst = 1'b1;
    endtask

    task automatic test_reset();
        @(negedge clk);
        rst = 1'b0;
        bus.i_valid = '0;
        bus.i_data = '0;
        bus.i_rptr_sync = '0;
        #1;
        n_checks++;
        if ({bus.o_wptr, bus.o_level, bus.o_full, bus.o_afull, bus.o_err} !== 13'd0) begin
            n_fail++;
            $display("FAIL reset_regs: got wptr=%0h level=%0d full=%0b afull=%0b err=%0b expected all 0",
                     bus.o_wptr, bus.o_level, bus.o_full, bus.o_afull, bus.o_err);
        end
        bus.i_valid = 2'b11;
        #1;
        n_checks++;
        if (bus.o_ready !== 2'b00 || bus.o_wen !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_ready: got ready=%b wen=%b expected 00/0", bus.o_ready, bus.o_wen);
        end
        bus.i_valid = '0;
        @(negedge clk);
        rst = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            #1;
            n_checks++;
            if (bus.o_wen !== 1'b0 || bus.o_level !== 5'd0) begin
                n_fail++;
                $display("FAIL idle[%0d]: got wen=%b level=%0d expected 0/0", i, bus.o_wen, bus.o_level);
            end
        end
    endtask

    task automatic test_fill();
        for (int i = 0; i < 16; i++) begin
            @(negedge clk);
            bus.i_valid = 2'b01;
            bus.i_data = {8'h00, 8'(i)};
            #1;
            n_checks++;
            if (bus.o_ready !== 2'b01 || bus.o_wen !== 1'b1 || bus.o_waddr !== 4'(i) || bus.o_wdata !== 8'(i)) begin
                n_fail++;
                $display("FAIL fill_write[%0d]: got ready=%b wen=%b waddr=%0d wdata=%0h expected 01/1/%0d/%0h",
                         i, bus.o_ready, bus.o_wen, bus.o_waddr, bus.o_wdata, i, i);
            end
            @(posedge clk);
            #1;
            n_checks++;
            if (bus.o_level !== 5'(i + 1) || bus.o_afull !== (i + 1 >= AT) || bus.o_full !== (i == 15)) begin
                n_fail++;
                $display("FAIL fill_flags[%0d]: got level=%0d afull=%b full=%b expected %0d/%b/%b",
                         i, bus.o_level, bus.o_afull, bus.o_full, i + 1, (i + 1 >= AT), (i == 15));
            end
        end
        @(negedge clk);
        #1;
        n_checks++;
        if (bus.o_ready !== 2'b00 || bus.o_wen !== 1'b0) begin
            n_fail++;
            $display("FAIL fill_17th: got ready=%b wen=%b expected 00/0", bus.o_ready, bus.o_wen);
        end
        @(posedge clk);
        #1;
        n_checks++;
        if (bus.o_full !== 1'b1 || bus.o_level !== 5'd16 || bus.o_wptr !== 5'b11000) begin
            n_fail++;
            $display("FAIL fill_hold: got full=%b level=%0d wptr=%b expected 1/16/11000",
                     bus.o_full, bus.o_level, bus.o_wptr);
        end
    endtask

    task automatic test_full_release();
        @(negedge clk);
        bus.i_valid = '0;
        bus.i_rptr_sync = 5'b00001;
        @(posedge clk);
        #1;
        n_checks++;
        if (bus.o_full !== 1'b0 || bus.o_level !== 5'd15 || bus.o_afull !== 1'b1) begin
            n_fail++;
            $display("FAIL release_flags: got full=%b level=%0d afull=%b expected 0/15/1",
                     bus.o_full, bus.o_level, bus.o_afull);
        end
        @(negedge clk);
        bus.i_valid = 2'b01;
        bus.i_data = {8'h00, 8'hAA};
        #1;
        n_checks++;
        if (bus.o_ready !== 2'b01 || bus.o_waddr !== 4'd0 || bus.o_wdata !== 8'hAA) begin
            n_fail++;
            $display("FAIL release_write: got ready=%b waddr=%0d wdata=%0h expected 01/0/aa",
                     bus.o_ready, bus.o_waddr, bus.o_wdata);
        end
        @(posedge clk);
        #1;
        n_checks++;
        if (bus.o_full !== 1'b1 || bus.o_level !== 5'd16 || bus.o_wptr !== 5'b11001 || bus.o_err !== 1'b0) begin
            n_fail++;
            $display("FAIL release_refull: got full=%b level=%0d wptr=%b err=%b expected 1/16/11001/0",
                     bus.o_full, bus.o_level, bus.o_wptr, bus.o_err);
        end
        @(negedge clk);
        bus.i_valid = '0;
    endtask

    task automatic test_round_robin();
        logic [1:0] rr_exp [4] = '{2'b01, 2'b10, 2'b01, 2'b10};
        apply_reset();
        bus.i_data = {8'h22, 8'h11};
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            bus.i_valid = 2'b11;
            #1;
            n_checks++;
            if (bus.o_ready !== rr_exp[i] || bus.o_waddr !== 4'(i) || bus.o_wdata !== (rr_exp[i][0] ? 8'h11 : 8'h22)) begin
                n_fail++;
                $display("FAIL rr_alt[%0d]: got ready=%b waddr=%0d wdata=%0h expected %b/%0d/%0h",
                         i, bus.o_ready, bus.o_waddr, bus.o_wdata, rr_exp[i], i, (rr_exp[i][0] ? 8'h11 : 8'h22));
            end
        end
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            bus.i_valid = 2'b10;
            #1;
            n_checks++;
            if (bus.o_ready !== 2'b10 || bus.o_waddr !== 4'(4 + i) || bus.o_wdata !== 8'h22) begin
                n_fail++;
                $display("FAIL rr_single[%0d]: got ready=%b waddr=%0d wdata=%0h expected 10/%0d/22",
                         i, bus.o_ready, bus.o_waddr, bus.o_wdata, 4 + i);
            end
        end
        @(negedge clk);
        bus.i_valid = 2'b11;
        #1;
        n_checks++;
        if (bus.o_ready !== 2'b01) begin
            n_fail++;
            $display("FAIL rr_return: got ready=%b expected 01", bus.o_ready);
        end
        @(posedge clk);
        #1;
        n_checks++;
        if (bus.o_level !== 5'd8) begin
            n_fail++;
            $display("FAIL rr_level: got %0d expected 8", bus.o_level);
        end
        @(negedge clk);
        bus.i_valid = '0;
    endtask

    task automatic test_wrap();
        logic [4:0] prev_wptr;
        int         r;
        apply_reset();
        prev_wptr = 5'd0;
        for (int i = 0; i < 40; i++) begin
            r = (i < 4) ? 0 : i - 3;
            @(negedge clk);
            bus.i_valid = 2'b01;
            bus.i_data = {8'h00, 8'(i)};
            bus.i_rptr_sync = gray5(5'(r));
            #1;
            n_checks++;
            if (bus.o_ready !== 2'b01 || bus.o_waddr !== 4'(i)) begin
                n_fail++;
                $display("FAIL wrap_write[%0d]: got ready=%b waddr=%0d expected 01/%0d",
                         i, bus.o_ready, bus.o_waddr, i % 16);
            end
            @(posedge clk);
            #1;
            n_checks++;
            if (bus.o_wptr !== gray5(5'(i + 1)) || bus.o_level !== 5'(i + 1 - r) || bus.o_err !== 1'b0) begin
                n_fail++;
                $display("FAIL wrap_ptr[%0d]: got wptr=%b level=%0d err=%b expected %b/%0d/0",
                         i, bus.o_wptr, bus.o_level, bus.o_err, gray5(5'(i + 1)), i + 1 - r);
            end
            n_checks++;
            if ($countones(bus.o_wptr ^ prev_wptr) != 1) begin
                n_fail++;
                $display("FAIL wrap_gray_step[%0d]: got %b -> %b expected a 1-bit change", i, prev_wptr, bus.o_wptr);
            end
            prev_wptr = bus.o_wptr;
        end
        @(negedge clk);
        bus.i_valid = '0;
    endtask

    task automatic test_err_reset();
        apply_reset();
        @(negedge clk);
        bus.i_rptr_sync = 5'b00011;
        @(posedge clk);
        #1;
        n_checks++;
        if (bus.o_err !== 1'b1) begin
            n_fail++;
            $display("FAIL err_set: got %b expected 1", bus.o_err);
        end
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            bus.i_valid = 2'b01;
            #1;
            n_checks++;
            if (bus.o_wen !== 1'b1) begin
                n_fail++;
                $display("FAIL err_nonblocking[%0d]: got wen=%b expected 1", i, bus.o_wen);
            end
        end
        @(negedge clk);
        #1;
        rst = 1'b0;
        #1;
        n_checks++;
        if (bus.o_err !== 1'b0 || bus.o_wptr !== 5'd0 || bus.o_level !== 5'd0 ||
            bus.o_wen !== 1'b0 || bus.o_ready !== 2'b00) begin
            n_fail++;
            $display("FAIL midburst_reset: got err=%b wptr=%b level=%0d wen=%b ready=%b expected 0/00000/0/0/00",
                     bus.o_err, bus.o_wptr, bus.o_level, bus.o_wen, bus.o_ready);
        end
        bus.i_valid = '0;
        bus.i_rptr_sync = '0;
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        rst = 1'b0;
        bus.i_valid = '0;
        bus.i_data = '0;
        bus.i_rptr_sync = '0;
        test_reset();
        test_fill();
        test_full_release();
        test_round_robin();
        test_wrap();
        test_err_reset();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
